// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encodings, lamp bit order and lamp decode for intersection_sequencer
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_AR_N = 3'd0,
        PH_N_G  = 3'd1,
        PH_N_Y  = 3'd2,
        PH_AR_E = 3'd3,
        PH_E_G  = 3'd4,
        PH_E_Y  = 3'd5,
        PH_WALK = 3'd6
    } phase_t;

    // Lamp vector bit order: {NR, NY, NG, ER, EY, EG}
    localparam int LAMP_NR = 5;
    localparam int LAMP_NY = 4;
    localparam int LAMP_NG = 3;
    localparam int LAMP_ER = 2;
    localparam int LAMP_EY = 1;
    localparam int LAMP_EG = 0;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [5:0] lamp_decode(input phase_t s);
        return (s == PH_N_G) ? 6'b001_100
             : (s == PH_N_Y) ? 6'b010_100
             : (s == PH_E_G) ? 6'b100_001
             : (s == PH_E_Y) ? 6'b100_010
             :                 6'b100_100;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: per-phase tick counter, cleared on state entry, saturating at lim-1, with expire flag
module phase_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          clr,
    input  logic [CW-1:0] lim,
    output logic [CW-1:0] cnt,
    output logic          expire
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_lim;

    always_comb begin
        at_lim = (cnt_q == lim - CW'(1));
        expire = tick && at_lim;
        cnt_d  = clr ? '0 : (tick && !at_lim) ? cnt_q + CW'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/intersection_sequencer.sv
// intersection_sequencer: two-way timed phase sequencer with demand latches and Moore lamp outputs.
// Define PED_WALK_EN to add the pedestrian WALK phase after a yellow when the ped latch is set.
module intersection_sequencer
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 5
) (
    input  logic       clk,
    input  logic       R,
    input  logic       tick,
    input  logic       S_N,
    input  logic       S_E,
    input  logic       P,
    output logic       NR,
    output logic       NY,
    output logic       NG,
    output logic       ER,
    output logic       EY,
    output logic       EG,
    output logic       WALK,
    output logic [2:0] phase
);

    localparam int MX = imax(imax(GREEN_MAX, YELLOW_T), imax(ALLRED_T, WALK_T));
    localparam int CW = $clog2(MX + 1);

    phase_t        state_q, state_d;
    logic          dem_n_q, dem_n_d, dem_e_q, dem_e_d;
    logic [5:0]    lamps_q, lamps_d;
    logic [CW-1:0] lim, cnt;
    logic          expire, clr, min_ok, max_ok, ped_go;

    phase_timer #(.CW(CW)) u_timer (
        .clk    (clk),
        .rst    (R),
        .tick   (tick),
        .clr    (clr),
        .lim    (lim),
        .cnt    (cnt),
        .expire (expire)
    );

`ifdef PED_WALK_EN
    logic ped_q, ped_d, ret_e_q, ret_e_d, walk_q, walk_d;
    assign ped_go = ped_q;
    always_comb begin
        ped_d   = (state_d == PH_WALK && state_q != PH_WALK) ? 1'b0 : P ? 1'b1 : ped_q;
        ret_e_d = (state_q == PH_N_Y) ? 1'b1 : (state_q == PH_E_Y) ? 1'b0 : ret_e_q;
        walk_d  = (state_d == PH_WALK);
    end
    assign WALK = walk_q;
`else
    logic unused_p;
    assign unused_p = P;
    assign ped_go   = 1'b0;
    assign WALK     = 1'b0;
`endif

    assign min_ok = (cnt >= CW'(GREEN_MIN - 1));
    assign max_ok = (cnt >= CW'(GREEN_MAX - 1));

    always_comb begin
        state_d = state_q;
        lim     = CW'(ALLRED_T);
        case (state_q)
            PH_AR_N: state_d = expire ? PH_N_G : state_q;
            PH_N_G: begin
                lim     = CW'(GREEN_MAX);
                state_d = (tick && dem_e_q && ((min_ok && !S_N) || max_ok)) ? PH_N_Y : state_q;
            end
            PH_N_Y: begin
                lim     = CW'(YELLOW_T);
                state_d = expire ? (ped_go ? PH_WALK : PH_AR_E) : state_q;
            end
            PH_AR_E: state_d = expire ? PH_E_G : state_q;
            PH_E_G: begin
                lim     = CW'(GREEN_MAX);
                state_d = (tick && dem_n_q && ((min_ok && !S_E) || max_ok)) ? PH_E_Y : state_q;
            end
            PH_E_Y: begin
                lim     = CW'(YELLOW_T);
                state_d = expire ? (ped_go ? PH_WALK : PH_AR_N) : state_q;
            end
`ifdef PED_WALK_EN
            PH_WALK: begin
                lim     = CW'(WALK_T);
                state_d = expire ? (ret_e_q ? PH_AR_E : PH_AR_N) : state_q;
            end
`endif
            default: state_d = PH_AR_N;
        endcase
        clr = (state_d != state_q);
        // Clear on green entry wins over a same-cycle sensor set.
        dem_n_d = (state_d == PH_N_G && state_q != PH_N_G) ? 1'b0
                : (state_q != PH_N_G && S_N) ? 1'b1 : dem_n_q;
        dem_e_d = (state_d == PH_E_G && state_q != PH_E_G) ? 1'b0
                : (state_q != PH_E_G && S_E) ? 1'b1 : dem_e_q;
        lamps_d = lamp_decode(state_d);
    end

    always_ff @(posedge clk) begin
        if (R) begin
            state_q <= PH_AR_N;
            dem_n_q <= 1'b0;
            dem_e_q <= 1'b0;
            lamps_q <= lamp_decode(PH_AR_N);
`ifdef PED_WALK_EN
            ped_q   <= 1'b0;
            ret_e_q <= 1'b0;
            walk_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dem_n_q <= dem_n_d;
            dem_e_q <= dem_e_d;
            lamps_q <= lamps_d;
`ifdef PED_WALK_EN
            ped_q   <= ped_d;
            ret_e_q <= ret_e_d;
            walk_q  <= walk_d;
`endif
        end
    end

    assign NR    = lamps_q[LAMP_NR];
    assign NY    = lamps_q[LAMP_NY];
    assign NG    = lamps_q[LAMP_NG];
    assign ER    = lamps_q[LAMP_ER];
    assign EY    = lamps_q[LAMP_EY];
    assign EG    = lamps_q[LAMP_EG];
    assign phase = state_q;

endmodule

// File: tb/tb_intersection_sequencer.sv
// tb_intersection_sequencer: directed checks of phase sequencing, timing, demand latches and reset
module tb_intersection_sequencer;

    logic       clk = 1'b0;
    logic       R = 1'b1, tick = 1'b0, S_N = 1'b0, S_E = 1'b0, P = 1'b0;
    logic       NR, NY, NG, ER, EY, EG, WALK;
    logic [2:0] phase;
    logic [6:0] lamps;
    int         n_chk = 0, n_pass = 0;

    localparam logic [6:0] L_AR = 7'b0_100_100;
    localparam logic [6:0] L_NG = 7'b0_001_100;
    localparam logic [6:0] L_NY = 7'b0_010_100;
    localparam logic [6:0] L_EG = 7'b0_100_001;
    localparam logic [6:0] L_EY = 7'b0_100_010;
    localparam logic [6:0] L_WK = 7'b1_100_100;

    intersection_sequencer dut (
        .clk   (clk),
        .R     (R),
        .tick  (tick),
        .S_N   (S_N),
        .S_E   (S_E),
        .P     (P),
        .NR    (NR),
        .NY    (NY),
        .NG    (NG),
        .ER    (ER),
        .EY    (EY),
        .EG    (EG),
        .WALK  (WALK),
        .phase (phase)
    );

    always #5 clk = ~clk;
    assign lamps = {WALK, NR, NY, NG, ER, EY, EG};

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic chk_st(input string tag, input int ph, input logic [6:0] lp);
        check({tag, ".phase"}, int'(phase), ph);
        check({tag, ".lamps"}, int'(lamps), int'(lp));
    endtask

    // One tick period: three idle clocks then a one-clock strobe; returns at the negedge after it.
    task automatic tk(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic pulse_se();
        S_E = 1'b1;
        @(negedge clk);
        S_E = 1'b0;
    endtask

    task automatic pulse_sn();
        S_N = 1'b1;
        @(negedge clk);
        S_N = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        R = 1'b1;
        tick = 1'b1;
        repeat (2) @(negedge clk);
        R = 1'b0;
        tick = 1'b0;
    endtask

    initial begin
        do_reset();
        chk_st("reset", 0, L_AR);
        tk(1);
        chk_st("first_green", 1, L_NG);
        tk(20);
        chk_st("green_rest", 1, L_NG);

        do_reset();
        tk(1);
        pulse_se();
        tk(3);
        chk_st("min_hold_t3", 1, L_NG);
        tk(1);
        chk_st("min_yield_t4", 2, L_NY);
        tk(2);
        chk_st("yellow_t2", 2, L_NY);
        tk(1);
        chk_st("allred_e", 3, L_AR);
        tk(1);
        chk_st("east_green", 4, L_EG);
        tk(6);
        chk_st("east_rest", 4, L_EG);
        pulse_sn();
        tk(1);
        chk_st("east_yield", 5, L_EY);
        tk(3);
        chk_st("allred_n", 0, L_AR);
        tk(1);
        tk(15);
        chk_st("dem_e_cleared", 1, L_NG);

        do_reset();
        tk(1);
        S_N = 1'b1;
        pulse_se();
        tk(4);
        chk_st("maxout_t4", 1, L_NG);
        tk(7);
        chk_st("maxout_t11", 1, L_NG);
        tk(1);
        chk_st("maxout_t12", 2, L_NY);
        S_N = 1'b0;
        tk(3);
        chk_st("maxout_ar", 3, L_AR);
        repeat (3) @(negedge clk);
        tick = 1'b1;
        S_E  = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk_st("se_on_entry", 4, L_EG);
        tk(8);
        S_E = 1'b0;
        chk_st("se_held_rest", 4, L_EG);
        pulse_sn();
        tk(4);
        tk(1);
        chk_st("back_north", 1, L_NG);
        tk(10);
        chk_st("dem_e_not_set", 1, L_NG);

        pulse_se();
        tk(1);
        chk_st("rest_yield", 2, L_NY);
        repeat (20) @(negedge clk);
        chk_st("no_tick_hold", 2, L_NY);
        tk(1);
        R   = 1'b1;
        S_N = 1'b1;
        @(negedge clk);
        chk_st("reset_mid_yellow", 0, L_AR);
        R   = 1'b0;
        S_N = 1'b0;
        tk(1);
        tk(10);
        chk_st("latches_reset", 1, L_NG);

`ifdef PED_WALK_EN
        do_reset();
        tk(1);
        P = 1'b1;
        pulse_se();
        P = 1'b0;
        tk(4);
        chk_st("ped_yellow", 2, L_NY);
        tk(3);
        chk_st("walk_entry", 6, L_WK);
        tk(4);
        chk_st("walk_t4", 6, L_WK);
        tk(1);
        chk_st("walk_to_ar_e", 3, L_AR);
        tk(1);
        chk_st("walk_east_green", 4, L_EG);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
